// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline constants, fetch FSM states and the IF/ID record
package pipeline_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HELD} fetch_state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush-over-stall-over-load priority
module if_id_reg import pipeline_pkg::*; #(
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic [31:0] pc_plus4_q,
  output logic        valid_q
);
  localparam if_id_t BUBBLE = if_id_t'{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h4, valid: 1'b0};
  if_id_t r;
  // flush bubbles, stall holds, otherwise load the offered instruction or a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= BUBBLE;
    else if (flush) r <= BUBBLE;
    else if (!stall) r <= load ? if_id_t'{instr: instr, pc: pc, pc_plus4: pc + 32'd4, valid: 1'b1} : BUBBLE;
  assign {instr_q, pc_q, pc_plus4_q, valid_q} = r;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with one-outstanding imem handshake and IF/ID register
module fetch_unit import pipeline_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic [31:0] PC_target_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_plus4_D,
  output logic        valid_D
);
  fetch_state_t state;
  logic [31:0] PC_F, pc_req, hold_instr, hold_pc;
  logic kill, take, held_load, grant;
  // take: a live response goes straight into IF/ID; only then may the next request overlap it
  assign take      = state == S_WAIT && imem_rvalid && !kill && !flush_D && !stall_D;
  assign held_load = state == S_HELD && !stall_D;
  assign imem_req  = !stall_F && (state == S_REQ || take);
  assign imem_addr = PC_F;
  assign grant     = imem_req && imem_gnt;
  // fetch FSM, PC, in-flight PC, kill flag and hold buffer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= S_BOOT;
      PC_F       <= RESET_PC;
      pc_req     <= '0;
      kill       <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
    end else begin
      PC_F <= flush_D ? {PC_target_D[31:2], 2'b00} : grant ? PC_F + 32'd4 : PC_F;
      if (grant) pc_req <= PC_F;
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ:
          if (grant) begin
            state <= S_WAIT;
            kill  <= flush_D;
          end
        S_WAIT:
          if (!imem_rvalid) kill <= kill || flush_D;
          else if (kill || flush_D) begin
            kill  <= 1'b0;
            state <= S_REQ;
          end else if (stall_D) begin
            hold_instr <= imem_rdata;
            hold_pc    <= pc_req;
            state      <= S_HELD;
          end else if (!grant) state <= S_REQ;
        S_HELD: if (flush_D || !stall_D) state <= S_REQ;
        default: state <= S_BOOT;
      endcase
    end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall_D),
    .flush      (flush_D),
    .load       (take || held_load),
    .instr      (held_load ? hold_instr : imem_rdata),
    .pc         (held_load ? hold_pc : pc_req),
    .instr_q    (instr_D),
    .pc_q       (PC_D),
    .pc_plus4_q (PC_plus4_D),
    .valid_q    (valid_D)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios against a latency-configurable imem model and an IF/ID scoreboard
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, stall_F = 1'b0, stall_D = 1'b0, flush_D = 1'b0;
  logic [31:0] PC_target_D = '0;
  logic imem_req, imem_gnt, imem_rvalid, valid_D;
  logic [31:0] imem_addr, imem_rdata, instr_D, PC_D, PC_plus4_D;
  int tests = 0, fails = 0;
  int lat = 1, gnt_delay = 0, lcnt = 0, wait_cnt = 0, outst = 0;
  logic pend = 1'b0, upd = 1'b0, pw = 1'b0;
  logic [31:0] paddr = '0, pa = '0, exp_pc;
  logic [31:0] sb[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .PC_target_D(PC_target_D), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .PC_D(PC_D), .PC_plus4_D(PC_plus4_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0513_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input int l, input int g);
    rst = 1'b1;
    sb.delete();
    lat = l;
    gnt_delay = g;
    stall_F = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && sb.size() > 0; i++) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  assign imem_gnt    = imem_req && (wait_cnt >= gnt_delay);
  assign imem_rvalid = pend && lcnt == 0;
  assign imem_rdata  = mem(paddr);

  always @(posedge clk) begin
    wait_cnt <= (imem_req && !imem_gnt) ? wait_cnt + 1 : 0;
    if (imem_req && imem_gnt) begin
      pend  <= 1'b1;
      paddr <= imem_addr;
      lcnt  <= lat - 1;
    end else if (imem_rvalid) pend <= 1'b0;
    else if (pend) lcnt <= lcnt - 1;
  end

  always @(posedge clk) upd <= !stall_D || flush_D;

  always @(negedge clk)
    if (!rst && upd && valid_D && sb.size() > 0) begin
      exp_pc = sb.pop_front();
      chk("PC_D", PC_D, exp_pc);
      chk("instr_D", instr_D, mem(exp_pc));
      chk("PC_plus4_D", PC_plus4_D, exp_pc + 32'd4);
    end

  always @(negedge clk)
    if (rst) begin
      outst = 0;
      pw = 1'b0;
    end else begin
      if (pw && !stall_F) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_held", imem_addr, pa);
      end
      if (imem_req && imem_gnt) chk("one_outstanding", 32'(outst != 0 && !imem_rvalid), 32'd0);
      outst = (imem_req && imem_gnt) ? 1 : imem_rvalid ? 0 : outst;
      pw = imem_req && !imem_gnt && !flush_D;
      pa = imem_addr;
    end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_D, 32'h13);
    chk("rst_pc", PC_D, 32'h0);
    chk("rst_pc4", PC_plus4_D, 32'h4);
    chk("rst_valid", 32'(valid_D), 32'd0);
    // zero-wait streaming from address 0
    for (int i = 0; i < 4; i++) sb.push_back(32'(4 * i));
    rst = 1'b0;
    #1 chk("boot_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("c3_valid", 32'(valid_D), 32'd0);
    tick();
    chk("c4_valid", 32'(valid_D), 32'd1);
    chk("c4_pc", PC_D, 32'h0);
    tick();
    chk("c5_pc", PC_D, 32'h4);
    tick();
    chk("c6_pc", PC_D, 32'h8);
    wait_empty();
    // decode stall while a response arrives
    restart(1, 0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    repeat (3) tick();
    stall_F = 1'b1;
    stall_D = 1'b1;
    #1 chk("stall_noreq0", 32'(imem_req), 32'd0);
    tick();
    chk("stall_noreq1", 32'(imem_req), 32'd0);
    chk("stall_hold_pc", PC_D, 32'h0);
    tick();
    chk("stall_noreq2", 32'(imem_req), 32'd0);
    chk("stall_hold_valid", 32'(valid_D), 32'd1);
    tick();
    stall_F = 1'b0;
    stall_D = 1'b0;
    #1 chk("held_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("held_enter_pc", PC_D, 32'h4);
    chk("held_enter_valid", 32'(valid_D), 32'd1);
    tick();
    chk("held_bubble", 32'(valid_D), 32'd0);
    wait_empty();
    // redirect while 0x8 response is arriving
    restart(1, 0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    repeat (4) tick();
    chk("pre_flush_pc", PC_D, 32'h4);
    flush_D = 1'b1;
    PC_target_D = 32'h103;
    tick();
    flush_D = 1'b0;
    chk("flush_valid", 32'(valid_D), 32'd0);
    chk("flush_nop", instr_D, 32'h13);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", imem_addr, 32'h100);
    tick();
    chk("flush_bubble2", 32'(valid_D), 32'd0);
    tick();
    chk("target_pc", PC_D, 32'h100);
    chk("target_valid", 32'(valid_D), 32'd1);
    wait_empty();
    // slow memory, delayed grant, kill of an in-flight response
    restart(3, 2);
    sb.push_back(32'h0);
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    tick();
    chk("slow_req", 32'(imem_req), 32'd1);
    chk("slow_addr", imem_addr, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_gnt && imem_addr == 32'h4) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("grant4_seen", 32'(got), 32'd1);
    tick();
    flush_D = 1'b1;
    PC_target_D = 32'h200;
    #1 chk("kill_noreq", 32'(imem_req), 32'd0);
    tick();
    flush_D = 1'b0;
    chk("kill_bubble", 32'(valid_D), 32'd0);
    tick();
    chk("kill_drop_noreq", 32'(imem_req), 32'd0);
    tick();
    chk("kill_next_req", 32'(imem_req), 32'd1);
    chk("kill_next_addr", imem_addr, 32'h200);
    wait_empty();
    // reset in S_WAIT followed by a stray response
    restart(4, 0);
    tick();
    tick();
    rst = 1'b1;
    gnt_delay = 3;
    sb.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    tick();
    rst = 1'b0;
    tick();
    chk("rerun_req", 32'(imem_req), 32'd1);
    chk("rerun_addr", imem_addr, 32'h0);
    tick();
    chk("stray_valid0", 32'(valid_D), 32'd0);
    tick();
    chk("stray_ignored", 32'(valid_D), 32'd0);
    wait_empty();
    // redirect with stall_F to the top of the address space, then wrap
    restart(1, 0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'hFFFF_FFF8);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    repeat (4) tick();
    flush_D = 1'b1;
    stall_F = 1'b1;
    PC_target_D = 32'hFFFF_FFF8;
    tick();
    flush_D = 1'b0;
    stall_F = 1'b0;
    #1 chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    wait_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of decode and driven by the hazard unit's `stall_F`, `stall_D` and `flush_D`. It owns the fetch PC, runs a one-outstanding request/grant/response handshake to instruction memory, and owns the IF/ID pipeline register. It holds one instruction while decode is stalled and discards a wrong-path response after a taken branch or jump redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: `addi x0,x0,0`, the bubble inserted into IF/ID.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_F`  in  1  hold the PC; issue no new request.
- `stall_D`  in  1  hold IF/ID.
- `flush_D`  in  1  redirect taken: bubble IF/ID and kill the wrong path.
- `PC_target_D`  in  32  redirect address; valid when `flush_D`=1.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address, word aligned.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid, at least one cycle after `imem_gnt`.
- `imem_rdata`  in  32  instruction word.
- `instr_D`  out  32  IF/ID instruction.
- `PC_D`  out  32  IF/ID PC.
- `PC_plus4_D`  out  32  `PC_D`+4, registered.
- `valid_D`  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - `PC_F`: next address to request.
  - `pc_req`: PC of the in-flight request.
  - `kill`: drop the next response.
  - Hold buffer: `hold_instr`, `hold_pc`.
- States: `S_BOOT`, `S_REQ`, `S_WAIT`, `S_HELD`.
- `S_BOOT`: lasts one cycle after reset release, then goes to `S_REQ`.
- `S_REQ`:
  - `imem_req` = !`stall_F`; `imem_addr` = `PC_F`.
  - On `imem_gnt`: `pc_req` <= `PC_F`, `PC_F` <= `PC_F`+4, go to `S_WAIT`.
- `S_WAIT`, on `imem_rvalid`:
  - If `kill`: drop the response, clear `kill`, go to `S_REQ`.
  - Else if `stall_D`: capture the response into the hold buffer, go to `S_HELD`.
  - Else: load IF/ID with {`imem_rdata`, `pc_req`, valid=1}. In the same cycle, if !`stall_F`, assert `imem_req` at `PC_F`. On grant, stay in `S_WAIT` (back-to-back fetch); without grant, go to `S_REQ`.
- `S_HELD`: when `stall_D`=0, load IF/ID from the hold buffer and go to `S_REQ`.
- IF/ID cycles with no instruction to load (and no stall) load a bubble: `NOP_INSTR`, valid=0.
- IF/ID priority: `rst` > `flush_D` > `stall_D` > load.
- `flush_D`=1:
  - IF/ID <= bubble; `PC_F` <= `PC_target_D`.
  - `S_WAIT` without `rvalid` this cycle: set `kill`.
  - `S_WAIT` with `rvalid` this cycle: drop the response, go to `S_REQ`.
  - `S_REQ` granted this cycle: go to `S_WAIT` with `kill`=1.
  - `S_HELD`: discard the buffer, go to `S_REQ`.
  - `flush_D` overrides `PC_F`+4 and any same-cycle load.
- `flush_D` and `stall_F` together: the redirect still updates `PC_F`. The hazard unit never asserts both, but the behaviour is defined.
- Arithmetic: PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). Bits [1:0] of `PC_target_D` are forced to 0.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr_D`=`NOP_INSTR`, `PC_D`=0, `PC_plus4_D`=4, `valid_D`=0.
  - `PC_F`=`RESET_PC`, `kill`=0, state=`S_BOOT`.
- `imem_req` and `imem_addr` are combinational from state, `PC_F`, `stall_F` and `imem_rvalid`. No combinational path from `imem_gnt` to `imem_req`.
- Zero-wait memory (grant in the request cycle, `rvalid` the next cycle):
  - First `valid_D`=1 in the 4th cycle after reset release.
  - Sustained throughput: 1 instruction/cycle.
- Redirect penalty: the first target instruction reaches IF/ID 3 cycles after the `flush_D` cycle (zero-wait memory).
- `rst` asserted mid-transaction returns to `S_BOOT`. A late `rvalid` arriving in `S_BOOT` or `S_REQ` is ignored.

## Structure
- Shared `pipeline_pkg` holds:
  - `NOP_INSTR`;
  - the `fetch_state_t` enum;
  - the IF/ID record (`instr`, `pc`, `pc_plus4`, `valid`), reused by the ID/EX register.
- Natural sub-module: `if_id_reg`, the IF/ID register with stall/flush priority. The FSM, PC and hold buffer stay in `fetch_unit`.

## Test plan
- Zero-wait memory, program at 0x0 → `PC_D` = 0x0, 0x4, 0x8 on consecutive cycles from cycle 4; `valid_D`=1.
- `stall_F`=`stall_D`=1 for 3 cycles while a response arrives → the instruction is held in `S_HELD`, no `imem_req`, and it enters IF/ID the cycle the stall drops.
- `flush_D` with target 0x100 while the request for 0x8 is in `S_WAIT` → the 0x8 response is dropped, the next `imem_addr`=0x100, `valid_D`=0 during the bubble, then `PC_D`=0x100.
- `flush_D` in the same cycle as `imem_rvalid` → response dropped; IF/ID = `NOP_INSTR`/valid 0.
- Memory with 3-cycle `rvalid` latency and grant delayed 2 cycles → `imem_req` and `imem_addr` held stable until grant; at most one request outstanding.
- `rst` pulsed in `S_WAIT`, then a stray `rvalid` → ignored; fetch restarts at `RESET_PC`.
